// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default operand width.
package divider_pkg;
    localparam int DIV_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/cla_subtractor.sv
// W-bit subtractor built as a carry-lookahead adder of minuend + ~subtrahend + 1.
// borrow_o is the inverted carry-out: high when subtrahend > minuend.
module cla_subtractor #(
    parameter int W = 5
) (
    input  logic [W-1:0] minuend_i,
    input  logic [W-1:0] subtrahend_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W-1:0] g, p;
    logic [W:0]   c;

    assign g = minuend_i & ~subtrahend_i;
    assign p = minuend_i ^ ~subtrahend_i;

    // Each carry is expanded from generate/propagate terms and the carry-in of 1.
    always_comb begin : lookahead
        logic cc, pp;
        c[0] = 1'b1;
        for (int i = 0; i < W; i++) begin
            cc = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                cc = cc | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = cc | pp;
        end
    end

    assign diff_o   = p ^ c[W-1:0];
    assign borrow_o = ~c[W];
endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips RUN and reports straight from DONE.
module restoring_divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef DIV_ZERO_SHORTCUT_EN
    localparam bit SHORTCUT = 1'b1;
`else
    localparam bit SHORTCUT = 1'b0;
`endif

    state_e state_q, state_d;
    logic [WIDTH-1:0] b_q, b_d, q_q, q_d, r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d, dz_q, dz_d;

    // Partial remainder stays below b between steps, so its top bit is only
    // needed transiently in the shifted value.
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] r_step, q_step;
    logic             neg, last, b_zero;
    logic             unused_diff_msb;

    assign shifted         = {r_q, q_q[WIDTH-1]};
    assign r_step          = neg ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_step          = {q_q[WIDTH-2:0], ~neg};
    assign last            = (cnt_q == CW'(WIDTH - 1));
    assign b_zero          = (b == '0);
    assign unused_diff_msb = diff[WIDTH];

    cla_subtractor #(.W(WIDTH + 1)) u_sub (
        .minuend_i    (shifted),
        .subtrahend_i ({1'b0, b_q}),
        .diff_o       (diff),
        .borrow_o     (neg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (SHORTCUT && b_zero) ? DONE : RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Result registers load on the edge entering DONE so they are valid with done.
    always_comb begin
        b_d    = b_q;
        q_d    = q_q;
        r_d    = r_q;
        cnt_d  = cnt_q;
        zero_d = zero_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        case (state_q)
            IDLE: if (start) begin
                b_d    = b;
                q_d    = a;
                r_d    = '0;
                cnt_d  = '0;
                zero_d = b_zero;
                if (SHORTCUT && b_zero) begin
                    quo_d = '1;
                    rem_d = a;
                    dz_d  = 1'b1;
                end
            end
            RUN: begin
                q_d   = q_step;
                r_d   = r_step;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    quo_d = q_step;
                    rem_d = r_step;
                    dz_d  = zero_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q    <= '0;
            q_q    <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            zero_q <= 1'b0;
            quo_q  <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
        end else begin
            b_q    <= b_d;
            q_q    <= q_d;
            r_q    <= r_d;
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider at WIDTH=4; honours DIV_ZERO_SHORTCUT_EN for zero-divisor latency.
module tb_restoring_divider;
`ifdef DIV_ZERO_SHORTCUT_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 5;
`endif

    logic       clk = 1'b0;
    logic       rst, start, busy, done, div_zero;
    logic [3:0] a, b, quotient, remainder;
    int         checks = 0;
    int         failures = 0;

    restoring_divider #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start pulse, measure latency to done, check results and the following idle cycle.
    task automatic run_div(input logic [3:0] av, input logic [3:0] bv, input logic [3:0] eq,
                           input logic [3:0] er, input logic edz, input int elat, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (n == 1) chk({tag, " busy"}, busy, 1'b1);
            if (done) seen = 1;
        end
        chk({tag, " latency"}, n, elat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_zero"}, div_zero, edz);
        @(negedge clk);
        chk({tag, " done_pulse"}, done, 1'b0);
        chk({tag, " idle"}, busy, 1'b0);
        chk({tag, " hold"}, quotient, eq);
    endtask

    initial begin
        int dcnt;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        #2;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst quotient", quotient, 4'h0);
        chk("rst remainder", remainder, 4'h0);
        chk("rst div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, "13/3");
        run_div(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 5, "15/15");
        run_div(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 5, "2/9");
        run_div(4'd7, 4'd0, 4'hF, 4'd7, 1'b1, ZLAT, "7/0");

        // Start held high: a result every 6 cycles, operand changes during busy ignored.
        @(negedge clk);
        a = 4'd9; b = 4'd2; start = 1'b1;
        dcnt = 0;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            chk("held done", done, (n % 6) == 5);
            chk("held busy", busy, (n % 6) != 0);
            if (done) begin
                dcnt++;
                chk("held quotient", quotient, 4'd4);
                chk("held remainder", remainder, 4'd1);
            end
            if (n == 1 || n == 7) begin a = 4'd15; b = 4'd1; end
            if (n == 5 || n == 11) begin a = 4'd9; b = 4'd2; end
        end
        start = 1'b0;
        chk("held done count", dcnt, 3);

        // Reset during the second RUN cycle clears everything and suppresses done.
        @(negedge clk);
        @(negedge clk);
        a = 4'd13; b = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre-rst busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst quotient", quotient, 4'h0);
        chk("midrst remainder", remainder, 4'h0);
        chk("midrst div_zero", div_zero, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("post-rst no done", dcnt, 0);
        run_div(4'd10, 4'd4, 4'd2, 4'd2, 1'b0, 5, "10/4");

        // Exhaustive sweep against arithmetic reference.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                logic [3:0] av, bv, eq, er;
                av = 4'(ai); bv = 4'(bi);
                if (bi == 0) begin
                    eq = 4'hF; er = av;
                end else begin
                    eq = 4'(ai / bi); er = 4'(ai % bi);
                end
                run_div(av, bv, eq, er, bi == 0, (bi == 0) ? ZLAT : 5, "sweep");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 SHALL have port a, input, WIDTH bits: unsigned dividend.
REQ-006 SHALL have port b, input, WIDTH bits: unsigned divisor.
REQ-007 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-009 SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 SHALL have port div_zero, output, 1 bit: the current result came from a zero divisor.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1, register a and b, clear the iteration counter and enter RUN on that edge.
REQ-014 SHALL ignore start while in RUN or DONE; the captured operands are not altered.
REQ-015 SHALL, in RUN, perform one restoring step per cycle for exactly WIDTH cycles.
- Shift left: {R, Q}, where R is WIDTH+1 bits.
- Trial subtract: R minus {1'b0, b}, using the sub-module.
- Result non-negative: keep the difference and set Q[0]=1.
- Result negative: restore R and set Q[0]=0.
REQ-016 SHALL enter DONE after the WIDTH-th step.
- In DONE, done=1 for exactly one cycle.
- The state then returns to IDLE.
REQ-017 SHALL assert done exactly WIDTH+1 cycles after the edge that accepts start.
REQ-018 SHALL assert busy in RUN and DONE and deassert it in IDLE.
REQ-019 SHALL update quotient and remainder only in the DONE cycle and hold them until the next DONE.
- quotient = floor(a/b).
- remainder = a mod b.
REQ-020 SHALL, for b=0, produce quotient = all ones, remainder = a and div_zero=1.
- div_zero is updated together with quotient.
REQ-021 SHALL accept a start asserted in the cycle after DONE (IDLE) with no dead cycle.

Reset
REQ-022 SHALL, on rst=1, immediately and asynchronously force the following.
- State = IDLE.
- busy = 0, done = 0.
- quotient = 0, remainder = 0, div_zero = 0.
- Internal registers = 0.
REQ-023 SHALL abort any in-progress division when reset asserts mid-RUN, with no done pulse afterward.
REQ-024 SHALL resume accepting start on the first rising edge after rst deasserts.

Configuration
REQ-025 SHALL support macro DIV_ZERO_SHORTCUT_EN.
- Defined: a zero divisor captured in IDLE skips RUN and goes directly to DONE, so done asserts 1 cycle after the accepting edge. Results follow REQ-020.
- Undefined: a zero divisor runs the full WIDTH iterations. The natural restoring result equals REQ-020, and div_zero is still set.

Structure
REQ-026 SHALL take the FSM state enum (IDLE/RUN/DONE) and the default WIDTH constant from a shared package, divider_pkg.
REQ-027 SHALL perform the trial subtraction in one sub-module, cla_subtractor.
- Sub-module width: WIDTH+1 bits.
- Implementation: a carry-lookahead adder with the subtrahend inverted and carry-in = 1.
- Borrow = NOT carry-out, used as the negative flag.

Verification (WIDTH=4)
REQ-028 SHALL cover a=13, b=3, start pulse -> done after 5 cycles, quotient=4, remainder=1, div_zero=0.
REQ-029 SHALL cover a=15/b=15 -> 1/0, and a=2/b=9 -> 0/2; plus an exhaustive 256-pair sweep against a reference model.
REQ-030 SHALL cover a=7, b=0.
- With macro: done after 1 cycle.
- Without macro: done after 5 cycles.
- Both: quotient=4'hF, remainder=7, div_zero=1.
REQ-031 SHALL cover start held high continuously with a=9, b=2 -> back-to-back results 4/1.
- Exactly one done per 6 cycles.
- Start ignored during busy.
REQ-032 SHALL cover rst pulsed at RUN cycle 2.
- All outputs 0 immediately.
- No done pulse follows.
- The next start with a=10, b=4 -> 2/2.
